vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; next generation of the team's fixed 640x480 sync counter.
- Adds configurable timing, configurable sync polarity and a pixel-clock divider.
- All outputs are registered; adds pixel-enable input, line/frame start strobes and an optional frame counter.
- Sits between the system clock and the pixel/sprite renderers (Frogger playfield, HUD), which consume coordinates and strobes.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: counters, sync decode, strobes, pixel-clock divider.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enable,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic [CNT_W-1:0] o_Pixel_X,
  output logic [CNT_W-1:0] o_Pixel_Y,
  output logic             o_Pixel_Tick,
  output logic             o_Line_Start,
  output logic             o_Frame_Start,
  output logic [7:0]       o_Frame_Count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_range_err
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_range_err
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
  end
  if (CLK_DIV < 1) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             tick;
  logic             h_last;
  logic             v_last;
  logic             active_d;
  logic             hsync_d;
  logic             vsync_d;

  always_comb begin
    tick     = i_Enable && (div == DIV_LAST);
    h_last   = (h == H_LAST);
    v_last   = (v == V_LAST);
    active_d = (h < H_ACT_END) && (v < V_ACT_END);
    hsync_d  = ((h >= H_SYNC_BEG) && (h < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = ((v >= V_SYNC_BEG) && (v < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Outputs capture the decode of the pixel being consumed; h/v then move on.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      div           <= '0;
      h             <= '0;
      v             <= '0;
      o_HSync       <= ~HSYNC_POL;
      o_VSync       <= ~VSYNC_POL;
      o_Active      <= 1'b0;
      o_Pixel_X     <= '0;
      o_Pixel_Y     <= '0;
      o_Pixel_Tick  <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Pixel_Tick  <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
      if (i_Enable) begin
        div <= tick ? '0 : div + DIV_W'(1);
      end
      if (tick) begin
        o_HSync       <= hsync_d;
        o_VSync       <= vsync_d;
        o_Active      <= active_d;
        o_Pixel_X     <= h;
        o_Pixel_Y     <= v;
        o_Pixel_Tick  <= 1'b1;
        o_Line_Start  <= (h == '0);
        o_Frame_Start <= (h == '0) && (v == '0);
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + CNT_W'(1);
        end else begin
          h <= h + CNT_W'(1);
        end
      end
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      frame_cnt <= '0;
    end else if (tick && h_last && v_last) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign o_Frame_Count = frame_cnt;
`else
  assign o_Frame_Count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized enable/reset stimulus on a tiny raster, checked every cycle against a linear pixel-index model.
module tb_vga_timing_gen;

  localparam int unsigned H_ACTIVE = 8, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int unsigned V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam bit          HPOL = 1'b1, VPOL = 1'b0;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME_PIX = HT * VT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             hs, vs, act, tick, ls, fs;
  logic [CNT_W-1:0] px, py;
  logic [7:0]       fc;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CLK_DIV(CLK_DIV), .CNT_W(CNT_W)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .o_HSync(hs), .o_VSync(vs), .o_Active(act),
    .o_Pixel_X(px), .o_Pixel_Y(py),
    .o_Pixel_Tick(tick), .o_Line_Start(ls), .o_Frame_Start(fs),
    .o_Frame_Count(fc)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act_v, exp_v, $time);
    end
  endtask

  // Model state: p = pixels consumed since reset, en_cnt = enabled cycles since reset.
  int unsigned p = 0;
  int unsigned en_cnt = 0;
  int unsigned e_x = 0, e_y = 0, e_fc = 0;
  bit e_hs = ~HPOL, e_vs = ~VPOL, e_act = 0, e_tick = 0, e_ls = 0, e_fs = 0;
  bit saw_wrap = 0;
  logic [7:0] prev_fc = '0;

  task automatic model_edge(input bit r, input bit e);
    int unsigned h, v;
    if (r) begin
      p = 0; en_cnt = 0; e_x = 0; e_y = 0; e_fc = 0;
      e_hs = ~HPOL; e_vs = ~VPOL; e_act = 0; e_tick = 0; e_ls = 0; e_fs = 0;
    end else begin
      e_tick = 0; e_ls = 0; e_fs = 0;
      if (e) begin
        en_cnt++;
        if (en_cnt % CLK_DIV == 0) begin
          h = p % HT;
          v = (p / HT) % VT;
          e_x = h; e_y = v;
          e_act  = (h < H_ACTIVE) && (v < V_ACTIVE);
          e_hs   = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HPOL : ~HPOL;
          e_vs   = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VPOL : ~VPOL;
          e_tick = 1;
          e_ls   = (h == 0);
          e_fs   = (h == 0) && (v == 0);
          p++;
`ifdef VGA_FRAME_COUNTER_EN
          e_fc = (p / FRAME_PIX) % 256;
`endif
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    model_edge(r, e);
    @(negedge clk);
    check("hsync", 32'(hs), 32'(e_hs));
    check("vsync", 32'(vs), 32'(e_vs));
    check("active", 32'(act), 32'(e_act));
    check("pixel_x", 32'(px), e_x);
    check("pixel_y", 32'(py), e_y);
    check("pixel_tick", 32'(tick), 32'(e_tick));
    check("line_start", 32'(ls), 32'(e_ls));
    check("frame_start", 32'(fs), 32'(e_fs));
    check("frame_count", 32'(fc), e_fc);
    if (prev_fc == 8'd255 && fc == 8'd0) saw_wrap = 1;
    prev_fc = fc;
  endtask

  initial begin
    @(negedge clk);
    repeat (3) cycle(1'b1, 1'b0);
    // Mixed enable with occasional mid-frame resets.
    for (int i = 0; i < 8000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));
    end
    // Long free run: enough pixels to wrap the frame counter.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 256 * FRAME_PIX * CLK_DIV + 200; i++) begin
      cycle(1'b0, 1'b1);
    end
`ifdef VGA_FRAME_COUNTER_EN
    check("frame_count_wrap_seen", 32'(saw_wrap), 32'd1);
`else
    check("frame_count_tied_zero", 32'(fc), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
